nios2_debug_ocimem_ctrl: RTL and testbench
==========================================

Name: nios2_debug_ocimem_ctrl

Overview:
Debug on-chip memory (OCIMEM) controller directly downstream of the JTAG debug module's sysclk stage. It consumes jdo plus the take_action_ocimem_a/b and take_no_action_ocimem_a pulses, and owns a small debug RAM shared with the CPU's debug slave port. It produces MonDReg, monitor_ready and monitor_error, which feed back into the JTAG debug wrapper for shift-out.

Parameters:
ADDR_W, 8, debug RAM word-address width (2^ADDR_W 32-bit words); legal range 4..16.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
jdo  in  38  JTAG data from sysclk stage, valid with action pulses
take_action_ocimem_a  in  1  1-cycle pulse: command/address load
take_action_ocimem_b  in  1  1-cycle pulse: JTAG write data
take_no_action_ocimem_a  in  1  1-cycle pulse: streaming JTAG read
cpu_address  in  ADDR_W  CPU word address
cpu_regsel  in  1  1 = access control/status register, 0 = RAM
cpu_read  in  1  CPU read request
cpu_write  in  1  CPU write request
cpu_writedata  in  32  CPU write data
cpu_waitrequest  out  1  CPU request not accepted this cycle
cpu_readdata  out  32  CPU read data, valid with cpu_readdatavalid
cpu_readdatavalid  out  1  1-cycle read-data strobe
MonDReg  out  32  JTAG read-data register
MonAReg  out  ADDR_W  current JTAG word address
monitor_ready  out  1  monitor-ready flag set by CPU
monitor_error  out  1  monitor-error flag set by CPU

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: MonDReg=0, MonAReg=0, monitor_ready=0, monitor_error=0, cpu_readdatavalid=0, cpu_readdata=0, FSM=IDLE. RAM contents are not reset.
- jdo fields:
  - jdo[17] = ld_addr
  - jdo[18 +: ADDR_W] = new address
  - jdo[35] = rd_go
  - jdo[16] = clr_flags
  - jdo[34:3] = write data
- Any JTAG pulse counts as a JTAG op.
  - JTAG ops have absolute priority.
  - cpu_waitrequest = (cpu_read|cpu_write) & JTAG op this cycle.
  - The CPU request is accepted only when cpu_waitrequest=0.
- ocimem_a:
  - If ld_addr, MonAReg <= new address.
  - If clr_flags, clear both monitor flags; this wins over a same-cycle CPU set.
  - If rd_go, issue a RAM read at the effective address (new address if ld_addr, else MonAReg) and set MonAReg <= effective+1.
- ocimem_b: RAM[MonAReg] <= jdo[34:3]; MonAReg <= MonAReg+1.
- no_action_ocimem_a: read RAM[MonAReg]; MonAReg <= MonAReg+1.
- Simultaneous pulses: priority is ocimem_a > ocimem_b > no_action; lower-priority pulses are dropped.
- Address increment wraps modulo 2^ADDR_W.
- RAM is single-port with synchronous read, one access per cycle. A read issued in cycle N has data on the RAM output in N+1.
- FSM tags the owner of next-cycle RAM data. States:
  - IDLE
  - JRD: JTAG read issued last cycle
  - CRD: CPU RAM read issued last cycle
  - CREG: CPU register read last cycle
- FSM transitions:
  - Next state is chosen every cycle from the access issued that cycle; back-to-back accesses are legal.
  - JRD: MonDReg <= RAM q; visible in cycle N+2.
  - CRD: cpu_readdata <= RAM q, cpu_readdatavalid=1 in N+2.
  - CREG: cpu_readdata <= {zero-extended MonAReg in [31:16], 14'b0, monitor_error, monitor_ready}, valid in N+2.
- CPU RAM write: single cycle when accepted.
- CPU register write: wdata[0]=1 sets monitor_ready; wdata[1]=1 sets monitor_error; writing 0 has no effect.
- cpu_read and cpu_write both asserted: treated as write; no readdatavalid.
- Reset mid-read: the pending capture is discarded; no readdatavalid, MonDReg stays 0.

Optional Feature:
- Macro: OCIMEM_CPU_WRITE_PROTECT_EN.
- Defined: accepted CPU RAM writes are suppressed and instead set monitor_error. JTAG writes are unaffected, so the RAM behaves as debug ROM from the CPU side. Register writes are unaffected.
- Undefined: CPU RAM writes proceed normally.

Decomposition:
- Shared package nios2_debug_ocimem_pkg holds:
  - FSM state enum
  - jdo bit-position constants (LD_ADDR_BIT=17, ADDR_LSB=18, RD_GO_BIT=35, CLR_FLAGS_BIT=16, WDATA_MSB=34, WDATA_LSB=3)
  - status bit positions (READY_BIT=0, ERROR_BIT=1)
- One sub-module: nios2_debug_ocimem_ram, single-port, synchronous read, 2^ADDR_W x 32.

Test Plan:
- JTAG write-then-read:
  - ocimem_a with ld_addr=1, addr=0x10 -> MonAReg=0x10.
  - ocimem_b with data 0xDEADBEEF -> MonAReg=0x11.
  - ocimem_a with ld_addr=1, addr=0x10, rd_go=1 -> MonDReg=0xDEADBEEF two cycles later, MonAReg=0x11.
- Wrap: MonAReg=0xFF, no_action read -> MonAReg=0x00; MonDReg=RAM[0xFF].
- Contention:
  - cpu_read at addr 5 in the same cycle as ocimem_b -> cpu_waitrequest=1 for that cycle.
  - Next cycle the read is accepted; cpu_readdatavalid 2 cycles after acceptance.
- Flags:
  - CPU regsel write 0x3 -> both flags set.
  - ocimem_a with clr_flags=1 in the same cycle as a CPU write 0x1 -> both flags 0.
- Reset mid-read: assert reset in the cycle after cpu_read acceptance -> cpu_readdatavalid stays 0; all outputs at reset values.
- With OCIMEM_CPU_WRITE_PROTECT_EN: CPU write 0x12345678 to addr 3 -> RAM[3] unchanged (JTAG read confirms) and monitor_error=1.

Source files
------------

// File: rtl/nios2_debug_ocimem_pkg.sv
// Shared state encoding, jdo field positions and status-word layout for the debug OCIMEM controller.
package nios2_debug_ocimem_pkg;

  localparam int DATA_W        = 32;

  localparam int LD_ADDR_BIT   = 17;
  localparam int ADDR_LSB      = 18;
  localparam int RD_GO_BIT     = 35;
  localparam int CLR_FLAGS_BIT = 16;
  localparam int WDATA_MSB     = 34;
  localparam int WDATA_LSB     = 3;

  localparam int READY_BIT     = 0;
  localparam int ERROR_BIT     = 1;

  // Owner of the RAM data that appears on the next cycle.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_JRD,
    ST_CRD,
    ST_CREG
  } ocimem_state_e;

  function automatic logic [DATA_W-1:0] status_word(input logic [15:0] areg,
                                                    input logic        err,
                                                    input logic        rdy);
    logic [DATA_W-1:0] w;
    w            = '0;
    w[31:16]     = areg;
    w[ERROR_BIT] = err;
    w[READY_BIT] = rdy;
    return w;
  endfunction

endpackage

// File: rtl/nios2_debug_ocimem_ctrl_if.sv
// CPU debug-slave bus of the OCIMEM controller: request side, waitrequest and pipelined read data.
interface nios2_debug_ocimem_ctrl_if
  import nios2_debug_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) ();

  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_regsel;
  logic              cpu_read;
  logic              cpu_write;
  logic [DATA_W-1:0] cpu_writedata;
  logic              cpu_waitrequest;
  logic [DATA_W-1:0] cpu_readdata;
  logic              cpu_readdatavalid;

  modport master (
    output cpu_address, cpu_regsel, cpu_read, cpu_write, cpu_writedata,
    input  cpu_waitrequest, cpu_readdata, cpu_readdatavalid
  );

  modport slave (
    input  cpu_address, cpu_regsel, cpu_read, cpu_write, cpu_writedata,
    output cpu_waitrequest, cpu_readdata, cpu_readdatavalid
  );

endinterface

// File: rtl/nios2_debug_ocimem_ram.sv
// Single-port debug RAM, 2^ADDR_W x 32, synchronous read: data for an access at cycle N is on q in N+1.
module nios2_debug_ocimem_ram
  import nios2_debug_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    q_q <= mem[addr];
  end

  assign q = q_q;

endmodule

// File: rtl/nios2_debug_ocimem_ctrl.sv
// Debug OCIMEM controller: JTAG ops win over the CPU (waitrequest), reads return 2 cycles after issue.
// Define OCIMEM_CPU_WRITE_PROTECT_EN to turn CPU RAM writes into a monitor_error set (debug ROM).
module nios2_debug_ocimem_ctrl
  import nios2_debug_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [37:0]               jdo,
  input  logic                      take_action_ocimem_a,
  input  logic                      take_action_ocimem_b,
  input  logic                      take_no_action_ocimem_a,
  nios2_debug_ocimem_ctrl_if.slave  cpu,
  output logic [DATA_W-1:0]         MonDReg,
  output logic [ADDR_W-1:0]         MonAReg,
  output logic                      monitor_ready,
  output logic                      monitor_error
);

  ocimem_state_e     state_q, state_d;
  logic [DATA_W-1:0] mon_dreg_q, mon_dreg_d;
  logic [ADDR_W-1:0] mon_areg_q, mon_areg_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdv_q, rdv_d;

  logic              jtag_op, cpu_req, cpu_acc, cpu_wr, cpu_rd;
  logic              ld_addr, rd_go, clr_flags;
  logic [ADDR_W-1:0] new_addr, eff_addr;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_q;
  logic              unused_jdo;

  assign ld_addr   = jdo[LD_ADDR_BIT];
  assign rd_go     = jdo[RD_GO_BIT];
  assign clr_flags = jdo[CLR_FLAGS_BIT];
  assign new_addr  = jdo[ADDR_LSB +: ADDR_W];
  assign eff_addr  = ld_addr ? new_addr : mon_areg_q;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign jtag_op  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign cpu_req  = cpu.cpu_read | cpu.cpu_write;
  assign cpu.cpu_waitrequest = cpu_req & jtag_op;
  assign cpu_acc  = cpu_req & ~jtag_op;
  // A simultaneous read+write is a write; it never produces read data.
  assign cpu_wr   = cpu_acc & cpu.cpu_write;
  assign cpu_rd   = cpu_acc & cpu.cpu_read & ~cpu.cpu_write;

  // RAM port owner, address pointer and the tag for next cycle's RAM data.
  always_comb begin
    ram_we     = 1'b0;
    ram_addr   = cpu.cpu_address;
    ram_wdata  = cpu.cpu_writedata;
    mon_areg_d = mon_areg_q;
    state_d    = ST_IDLE;
    if (take_action_ocimem_a) begin
      mon_areg_d = eff_addr;
      if (rd_go) begin
        ram_addr   = eff_addr;
        mon_areg_d = eff_addr + ADDR_W'(1);
        state_d    = ST_JRD;
      end
    end else if (take_action_ocimem_b) begin
      ram_we     = 1'b1;
      ram_addr   = mon_areg_q;
      ram_wdata  = jdo[WDATA_MSB:WDATA_LSB];
      mon_areg_d = mon_areg_q + ADDR_W'(1);
    end else if (take_no_action_ocimem_a) begin
      ram_addr   = mon_areg_q;
      mon_areg_d = mon_areg_q + ADDR_W'(1);
      state_d    = ST_JRD;
    end else if (cpu_wr && !cpu.cpu_regsel) begin
`ifdef OCIMEM_CPU_WRITE_PROTECT_EN
      ram_we = 1'b0;
`else
      ram_we = 1'b1;
`endif
    end else if (cpu_rd) begin
      state_d = cpu.cpu_regsel ? ST_CREG : ST_CRD;
    end
  end

  always_comb begin
    ready_d = ready_q;
    error_d = error_q;
    if (cpu_wr && cpu.cpu_regsel) begin
      ready_d = ready_q | cpu.cpu_writedata[READY_BIT];
      error_d = error_q | cpu.cpu_writedata[ERROR_BIT];
    end
`ifdef OCIMEM_CPU_WRITE_PROTECT_EN
    if (cpu_wr && !cpu.cpu_regsel) begin
      error_d = 1'b1;
    end
`endif
    // A JTAG clear always beats a CPU set in the same cycle.
    if (take_action_ocimem_a && clr_flags) begin
      ready_d = 1'b0;
      error_d = 1'b0;
    end
  end

  always_comb begin
    mon_dreg_d = mon_dreg_q;
    rdata_d    = rdata_q;
    rdv_d      = 1'b0;
    case (state_q)
      ST_JRD:  mon_dreg_d = ram_q;
      ST_CRD: begin
        rdata_d = ram_q;
        rdv_d   = 1'b1;
      end
      ST_CREG: begin
        rdata_d = status_word(16'(mon_areg_q), error_q, ready_q);
        rdv_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mon_dreg_q <= '0;
      mon_areg_q <= '0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      rdata_q    <= '0;
      rdv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mon_dreg_q <= mon_dreg_d;
      mon_areg_q <= mon_areg_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      rdata_q    <= rdata_d;
      rdv_q      <= rdv_d;
    end
  end

  nios2_debug_ocimem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we & ~reset),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  assign MonDReg               = mon_dreg_q;
  assign MonAReg               = mon_areg_q;
  assign monitor_ready         = ready_q;
  assign monitor_error         = error_q;
  assign cpu.cpu_readdata      = rdata_q;
  assign cpu.cpu_readdatavalid = rdv_q;

endmodule

// File: tb/tb_nios2_debug_ocimem_ctrl.sv
// Bench for nios2_debug_ocimem_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_nios2_debug_ocimem_ctrl;

  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;
`ifdef OCIMEM_CPU_WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [37:0]   jdo;
  logic          take_a, take_b, take_na;
  logic [31:0]   MonDReg;
  logic [AW-1:0] MonAReg;
  logic          monitor_ready, monitor_error;

  nios2_debug_ocimem_ctrl_if #(.ADDR_W(AW)) cpu_if ();

  nios2_debug_ocimem_ctrl #(.ADDR_W(AW)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_action_ocimem_b    (take_b),
    .take_no_action_ocimem_a (take_na),
    .cpu                     (cpu_if),
    .MonDReg                 (MonDReg),
    .MonAReg                 (MonAReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    bit          to_cpu;
    logic [31:0] val;
  } rd_t;

  rd_t         pend[$];
  rd_t         ev;
  logic [31:0] m_mem [DEPTH];
  int          m_areg, eff, edge_n;
  logic [31:0] m_dreg, m_rdata;
  bit          m_rdy, m_err, m_rdv, m_live;

  initial begin
    edge_n = 0;
    m_live = 1'b0;
  end

  always @(posedge clk) begin
    edge_n++;
    m_rdv = 1'b0;
    if (reset) begin
      m_areg  = 0;
      m_dreg  = '0;
      m_rdata = '0;
      m_rdy   = 1'b0;
      m_err   = 1'b0;
      pend.delete();
      m_live  = 1'b1;
    end else if (m_live) begin
      while (pend.size() > 0 && pend[0].due == edge_n) begin
        ev = pend.pop_front();
        if (ev.to_cpu) begin
          m_rdv   = 1'b1;
          m_rdata = ev.val;
        end else begin
          m_dreg = ev.val;
        end
      end
      if (take_a) begin
        eff = jdo[17] ? int'(jdo[25:18]) : m_areg;
        if (jdo[35]) begin
          pend.push_back('{edge_n + 1, 1'b0, m_mem[eff]});
          m_areg = (eff + 1) % DEPTH;
        end else begin
          m_areg = eff;
        end
        if (jdo[16]) begin
          m_rdy = 1'b0;
          m_err = 1'b0;
        end
      end else if (take_b) begin
        m_mem[m_areg] = jdo[34:3];
        m_areg = (m_areg + 1) % DEPTH;
      end else if (take_na) begin
        pend.push_back('{edge_n + 1, 1'b0, m_mem[m_areg]});
        m_areg = (m_areg + 1) % DEPTH;
      end else if (cpu_if.cpu_write) begin
        if (cpu_if.cpu_regsel) begin
          m_rdy = m_rdy | cpu_if.cpu_writedata[0];
          m_err = m_err | cpu_if.cpu_writedata[1];
        end else if (WP) begin
          m_err = 1'b1;
        end else begin
          m_mem[cpu_if.cpu_address] = cpu_if.cpu_writedata;
        end
      end else if (cpu_if.cpu_read) begin
        if (cpu_if.cpu_regsel)
          pend.push_back('{edge_n + 1, 1'b1, {16'(m_areg), 14'b0, m_err, m_rdy}});
        else
          pend.push_back('{edge_n + 1, 1'b1, m_mem[cpu_if.cpu_address]});
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("MonAReg", 32'(MonAReg), 32'(m_areg));
      chk("MonDReg", MonDReg, m_dreg);
      chk("monitor_ready", 32'(monitor_ready), 32'(m_rdy));
      chk("monitor_error", 32'(monitor_error), 32'(m_err));
      chk("readdatavalid", 32'(cpu_if.cpu_readdatavalid), 32'(m_rdv));
      if (m_rdv) chk("readdata", cpu_if.cpu_readdata, m_rdata);
      chk("waitrequest", 32'(cpu_if.cpu_waitrequest),
          32'((cpu_if.cpu_read | cpu_if.cpu_write) & (take_a | take_b | take_na)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    take_a = 1'b0;
    take_b = 1'b0;
    take_na = 1'b0;
    jdo = '0;
    cpu_if.cpu_read = 1'b0;
    cpu_if.cpu_write = 1'b0;
    cpu_if.cpu_regsel = 1'b0;
    cpu_if.cpu_address = '0;
    cpu_if.cpu_writedata = '0;
  endtask

  function automatic logic [37:0] mk_a(input bit ld, input logic [7:0] ad, input bit rd, input bit clr);
    logic [37:0] j;
    j = '0;
    j[17] = ld;
    j[25:18] = ad;
    j[35] = rd;
    j[16] = clr;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic jop_a(input bit ld, input logic [7:0] ad, input bit rd, input bit clr);
    take_a = 1'b1;
    jdo = mk_a(ld, ad, rd, clr);
    cyc();
    take_a = 1'b0;
    jdo = '0;
  endtask

  task automatic jop_b(input logic [31:0] d);
    take_b = 1'b1;
    jdo = mk_b(d);
    cyc();
    take_b = 1'b0;
    jdo = '0;
  endtask

  task automatic jop_na();
    take_na = 1'b1;
    cyc();
    take_na = 1'b0;
  endtask

  logic [31:0] ram_init [DEPTH];
  logic [63:0] rnd;

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (3) cyc();
    chk("rst_MonDReg", MonDReg, 32'h0);
    chk("rst_MonAReg", 32'(MonAReg), 32'h0);
    chk("rst_ready", 32'(monitor_ready), 32'h0);
    chk("rst_error", 32'(monitor_error), 32'h0);
    chk("rst_rdv", 32'(cpu_if.cpu_readdatavalid), 32'h0);
    chk("rst_rdata", cpu_if.cpu_readdata, 32'h0);
    reset = 1'b0;

    // Fill the whole RAM so every later read has a known value.
    jop_a(1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      ram_init[i] = $urandom;
      jop_b(ram_init[i]);
    end
    chk("fill_wrap", 32'(MonAReg), 32'h0);

    // JTAG write then read back
    jop_a(1'b1, 8'h10, 1'b0, 1'b0);
    chk("ld_addr", 32'(MonAReg), 32'h10);
    jop_b(32'hDEADBEEF);
    chk("jwr_inc", 32'(MonAReg), 32'h11);
    jop_a(1'b1, 8'h10, 1'b1, 1'b0);
    chk("jrd_inc", 32'(MonAReg), 32'h11);
    chk("jrd_not_yet", MonDReg, 32'h0);
    cyc();
    chk("jrd_data", MonDReg, 32'hDEADBEEF);

    // Address wrap
    jop_a(1'b1, 8'hFF, 1'b0, 1'b0);
    jop_b(32'hCAFEF00D);
    chk("b_wrap", 32'(MonAReg), 32'h0);
    jop_a(1'b1, 8'hFF, 1'b0, 1'b0);
    jop_na();
    chk("na_wrap", 32'(MonAReg), 32'h0);
    cyc();
    chk("na_data", MonDReg, 32'hCAFEF00D);

    // CPU read colliding with a JTAG write
    jop_a(1'b1, 8'd5, 1'b0, 1'b0);
    jop_b(32'h0000_0555);
    cpu_if.cpu_address = 8'd5;
    cpu_if.cpu_read = 1'b1;
    take_b = 1'b1;
    jdo = mk_b(32'h77);
    #1 chk("cont_wait", 32'(cpu_if.cpu_waitrequest), 32'h1);
    cyc();
    take_b = 1'b0;
    jdo = '0;
    #1 chk("cont_accept", 32'(cpu_if.cpu_waitrequest), 32'h0);
    cyc();
    cpu_if.cpu_read = 1'b0;
    chk("cont_rdv_n1", 32'(cpu_if.cpu_readdatavalid), 32'h0);
    cyc();
    chk("cont_rdv_n2", 32'(cpu_if.cpu_readdatavalid), 32'h1);
    chk("cont_rdata", cpu_if.cpu_readdata, 32'h0000_0555);
    cyc();
    chk("cont_rdv_drop", 32'(cpu_if.cpu_readdatavalid), 32'h0);

    // Monitor flags
    cpu_if.cpu_regsel = 1'b1;
    cpu_if.cpu_write = 1'b1;
    cpu_if.cpu_writedata = 32'h3;
    cyc();
    chk("flag_set_rdy", 32'(monitor_ready), 32'h1);
    chk("flag_set_err", 32'(monitor_error), 32'h1);
    take_a = 1'b1;
    jdo = mk_a(1'b0, 8'h0, 1'b0, 1'b1);
    cpu_if.cpu_writedata = 32'h1;
    cyc();
    take_a = 1'b0;
    jdo = '0;
    cpu_if.cpu_write = 1'b0;
    chk("flag_clr_rdy", 32'(monitor_ready), 32'h0);
    chk("flag_clr_err", 32'(monitor_error), 32'h0);
    cpu_if.cpu_writedata = 32'h2;
    cpu_if.cpu_write = 1'b1;
    cyc();
    cpu_if.cpu_write = 1'b0;
    chk("flag_err_only", {30'b0, monitor_error, monitor_ready}, 32'h2);
    cpu_if.cpu_read = 1'b1;
    cyc();
    cpu_if.cpu_read = 1'b0;
    cpu_if.cpu_regsel = 1'b0;
    cyc();
    chk("creg_rdv", 32'(cpu_if.cpu_readdatavalid), 32'h1);
    chk("creg_rdata", cpu_if.cpu_readdata, 32'h0007_0002);

    // Read+write together is a write (and the write-protect case)
    jop_a(1'b0, 8'h0, 1'b0, 1'b1);
    cpu_if.cpu_address = 8'd3;
    cpu_if.cpu_write = 1'b1;
    cpu_if.cpu_read = 1'b1;
    cpu_if.cpu_writedata = 32'h12345678;
    cyc();
    idle_inputs();
    chk("cpu_wr_error", 32'(monitor_error), 32'(WP));
    cyc();
    chk("rw_no_rdv", 32'(cpu_if.cpu_readdatavalid), 32'h0);
    jop_a(1'b1, 8'd3, 1'b1, 1'b0);
    cyc();
    chk("cpu_wr_data", MonDReg, WP ? ram_init[3] : 32'h12345678);

    // Reset while a CPU read is in flight
    cpu_if.cpu_address = 8'd5;
    cpu_if.cpu_read = 1'b1;
    cyc();
    cpu_if.cpu_read = 1'b0;
    reset = 1'b1;
    cyc();
    chk("rstmid_rdv", 32'(cpu_if.cpu_readdatavalid), 32'h0);
    chk("rstmid_MonDReg", MonDReg, 32'h0);
    chk("rstmid_MonAReg", 32'(MonAReg), 32'h0);
    chk("rstmid_flags", {30'b0, monitor_error, monitor_ready}, 32'h0);
    chk("rstmid_rdata", cpu_if.cpu_readdata, 32'h0);
    cyc();
    chk("rstmid_rdv2", 32'(cpu_if.cpu_readdatavalid), 32'h0);
    reset = 1'b0;

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      rnd = {$urandom, $urandom};
      jdo = rnd[37:0];
      take_a  = !reset && ($urandom_range(0, 5) == 0);
      take_b  = !reset && ($urandom_range(0, 5) == 0);
      take_na = !reset && ($urandom_range(0, 5) == 0);
      cpu_if.cpu_read      = !reset && ($urandom_range(0, 4) < 2);
      cpu_if.cpu_write     = !reset && ($urandom_range(0, 4) < 2);
      cpu_if.cpu_regsel    = ($urandom_range(0, 3) == 0);
      cpu_if.cpu_address   = 8'($urandom);
      cpu_if.cpu_writedata = $urandom;
      cyc();
    end
    reset = 1'b0;
    idle_inputs();
    repeat (4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
